neuron_accumulator: RTL and testbench
=====================================

Name: neuron_accumulator

Overview:
- Consumer end of the integrator interface: takes the per-axon signed contributions produced by the integrators, one per handshake, and folds them into a single neuron's membrane potential.
- Once per timestep it applies leak, compares against threshold, applies the selected reset mode, and emits a spike through a valid/ready handshake toward the spike router.
- Sits directly downstream of the integrator inside each core's neuron block.
- Potential persists across timesteps.

Parameters:
- NUM_AXONS, 256: contributions accepted per timestep.
- LEAK_WIDTH, 9: signed leak value width.
- WEIGHT_WIDTH, 9: contribution width (two's complement).
- THRESHOLD_WIDTH, 9: signed threshold width; must be <= POTENTIAL_WIDTH.
- POTENTIAL_WIDTH, 9: signed membrane potential width.
- NUM_RESET_MODES, 2: number of reset modes; 0 = absolute, 1 = linear.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- tick_i  in  1  start-of-timestep pulse.
- contrib_valid_i  in  1  contribution valid.
- contrib_i  in  WEIGHT_WIDTH  contribution from integrator, interpreted signed.
- contrib_ready_o  out  1  accumulator accepts a contribution.
- leak_i  in  LEAK_WIDTH  signed leak added once per timestep.
- threshold_i  in  THRESHOLD_WIDTH  signed firing threshold.
- reset_potential_i  in  POTENTIAL_WIDTH  signed value loaded on absolute reset.
- reset_mode_i  in  $clog2(NUM_RESET_MODES)  reset mode select.
- spike_valid_o  out  1  spike pending.
- spike_ready_i  in  1  downstream accepts spike.
- potential_o  out  POTENTIAL_WIDTH  current membrane potential register.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the timestep completes.
- tick_overrun_o  out  1  one-cycle pulse when tick_i arrives while busy.

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE; potential=0; axon counter=0.
  - All outputs 0.
- States: IDLE, INTEG, LEAK, FIRE, SPIKE.
- IDLE:
  - contrib_ready_o=0.
  - On tick_i: counter←0, go to INTEG next cycle.
- INTEG:
  - contrib_ready_o=1.
  - Each cycle with contrib_valid_i=1: potential←sat(potential+sext(contrib_i)), counter++.
  - When the accepted contribution is number NUM_AXONS (counter==NUM_AXONS-1 at accept): go to LEAK.
  - No valid: hold state and counter, no timeout.
- LEAK (1 cycle): potential←sat(potential+sext(leak_i)), go to FIRE.
- FIRE (1 cycle): signed compare potential >= sext(threshold_i).
  - True, mode 0: potential←reset_potential_i.
  - True, mode 1: potential←sat(potential−sext(threshold_i)).
  - True: spike_valid_o←1 registered, go to SPIKE.
  - False: potential unchanged, done_o pulses next cycle, go to IDLE.
  - Undefined mode values (≥NUM_RESET_MODES) behave as mode 0.
- SPIKE:
  - spike_valid_o held high and stable until spike_ready_i=1 is sampled.
  - On that cycle, spike_valid_o drops next cycle, done_o pulses, go to IDLE.
- Arithmetic:
  - All operands sign-extended to POTENTIAL_WIDTH+1.
  - Result clamped to [−2^(P−1), 2^(P−1)−1].
- Registered outputs:
  - potential_o is the register itself.
  - contrib_ready_o is a function of state only, with no combinational path from contrib_valid_i.
- tick_i in any non-IDLE state: ignored, tick_overrun_o pulses 1 cycle; the timestep in progress is unaffected.
- tick_i on the same cycle done_o is set is treated as an overrun, because the state is not yet IDLE.
- Reset mid-operation: immediate return to reset values; any pending spike is dropped.
- Latency, tick to done with no spike and back-to-back valids: 1 (IDLE→INTEG) + NUM_AXONS + 1 (LEAK) + 1 (FIRE) cycles.

Test Plan:
- Basic accumulate, no spike:
  - NUM_AXONS=4, thr=100, leak=−1, contribs 10,20,−5,3 back-to-back.
  - Expect potential_o=27, no spike, done_o pulse 7 cycles after tick.
- Absolute reset:
  - thr=20, mode 0, reset_potential=−3, contribs 10×4, leak=0, spike_ready_i=1.
  - Expect spike_valid_o for 1 cycle, potential_o=−3.
- Linear reset with backpressure:
  - thr=20, mode 1, contribs 10×4, spike_ready_i low for 5 cycles.
  - Expect spike_valid_o stable for 5 cycles, potential_o=20, done_o only after handshake.
- Saturation (P=9):
  - Contribs 255,255,255,255 and leak=+10: expect 255.
  - Then a timestep of −255×4 with leak=−10: expect −256.
- Stalls and overrun:
  - Insert random valid gaps: final potential identical to the no-gap case.
  - tick_i during INTEG: tick_overrun_o pulse, contributions count unchanged.
- Async reset asserted in INTEG after 2 contributions:
  - Expect all outputs 0 immediately.
  - A fresh tick then starts a new timestep from potential 0.

Source files
------------

// File: rtl/neuron_accumulator.sv
// Single-neuron integrate-and-fire accumulator: folds per-axon contributions into a
// saturating membrane potential, then leaks, thresholds, resets and emits a spike.
module neuron_accumulator #(
    parameter int NUM_AXONS       = 256,
    parameter int LEAK_WIDTH      = 9,
    parameter int WEIGHT_WIDTH    = 9,
    parameter int THRESHOLD_WIDTH = 9,
    parameter int POTENTIAL_WIDTH = 9,
    parameter int NUM_RESET_MODES = 2,
    localparam int MODE_W = (NUM_RESET_MODES > 1) ? $clog2(NUM_RESET_MODES) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       tick_i,
    input  logic                       contrib_valid_i,
    input  logic [WEIGHT_WIDTH-1:0]    contrib_i,
    output logic                       contrib_ready_o,
    input  logic [LEAK_WIDTH-1:0]      leak_i,
    input  logic [THRESHOLD_WIDTH-1:0] threshold_i,
    input  logic [POTENTIAL_WIDTH-1:0] reset_potential_i,
    input  logic [MODE_W-1:0]          reset_mode_i,
    output logic                       spike_valid_o,
    input  logic                       spike_ready_i,
    output logic [POTENTIAL_WIDTH-1:0] potential_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       tick_overrun_o
);

    localparam int P     = POTENTIAL_WIDTH;
    localparam int CNT_W = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(NUM_AXONS - 1);
    localparam logic signed [P-1:0] POT_MAX  = {1'b0, {(P-1){1'b1}}};
    localparam logic signed [P-1:0] POT_MIN  = {1'b1, {(P-1){1'b0}}};
    localparam logic [MODE_W-1:0]   MODE_LINEAR = MODE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INTEG = 3'd1,
        S_LEAK  = 3'd2,
        S_FIRE  = 3'd3,
        S_SPIKE = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic signed [P-1:0]   potential_q, potential_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  spike_valid_q, spike_valid_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;

    logic signed [P:0]     pot_ext_s;
    logic signed [P:0]     contrib_ext_s;
    logic signed [P:0]     leak_ext_s;
    logic signed [P:0]     thr_ext_s;
    logic                  fire_s;
    logic                  cnt_last_s;

    // Clamp a P+1 bit sum back into the P bit potential range.
    function automatic logic signed [P-1:0] sat(input logic signed [P:0] v);
        logic signed [P-1:0] r;
        if (v[P] != v[P-1]) begin
            r = v[P] ? POT_MIN : POT_MAX;
        end else begin
            r = v[P-1:0];
        end
        return r;
    endfunction

    assign pot_ext_s     = (P+1)'(potential_q);
    assign contrib_ext_s = (P+1)'($signed(contrib_i));
    assign leak_ext_s    = (P+1)'($signed(leak_i));
    assign thr_ext_s     = (P+1)'($signed(threshold_i));
    assign fire_s        = (pot_ext_s >= thr_ext_s);
    assign cnt_last_s    = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = tick_i ? S_INTEG : S_IDLE;
            S_INTEG: state_d = (contrib_valid_i && cnt_last_s) ? S_LEAK : S_INTEG;
            S_LEAK:  state_d = S_FIRE;
            S_FIRE:  state_d = fire_s ? S_SPIKE : S_IDLE;
            S_SPIKE: state_d = spike_ready_i ? S_IDLE : S_SPIKE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; out-of-range modes fall back to absolute reset.
    always_comb begin
        potential_d   = potential_q;
        cnt_d         = cnt_q;
        spike_valid_d = spike_valid_q;
        done_d        = 1'b0;
        overrun_d     = tick_i && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (tick_i) begin
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_INTEG: begin
                if (contrib_valid_i) begin
                    potential_d = sat(pot_ext_s + contrib_ext_s);
                    cnt_d       = cnt_q + CNT_W'(1);
                end else begin
                    potential_d = potential_q;
                    cnt_d       = cnt_q;
                end
            end
            S_LEAK: begin
                potential_d = sat(pot_ext_s + leak_ext_s);
            end
            S_FIRE: begin
                if (fire_s) begin
                    spike_valid_d = 1'b1;
                    if (reset_mode_i == MODE_LINEAR) begin
                        potential_d = sat(pot_ext_s - thr_ext_s);
                    end else begin
                        potential_d = $signed(reset_potential_i);
                    end
                end else begin
                    done_d = 1'b1;
                end
            end
            S_SPIKE: begin
                if (spike_ready_i) begin
                    spike_valid_d = 1'b0;
                    done_d        = 1'b1;
                end else begin
                    spike_valid_d = 1'b1;
                end
            end
            default: begin
                spike_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            potential_q   <= '0;
            cnt_q         <= '0;
            spike_valid_q <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            potential_q   <= potential_d;
            cnt_q         <= cnt_d;
            spike_valid_q <= spike_valid_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign contrib_ready_o = (state_q == S_INTEG);
    assign busy_o          = (state_q != S_IDLE);
    assign spike_valid_o   = spike_valid_q;
    assign done_o          = done_q;
    assign tick_overrun_o  = overrun_q;
    assign potential_o     = potential_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized self-checking bench for neuron_accumulator against a plain-arithmetic
// integrate/leak/fire model of one neuron.
module tb_neuron_accumulator;

    localparam int NA = 4;
    localparam int P  = 9;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       tick_i = 1'b0;
    logic       contrib_valid_i = 1'b0;
    logic [8:0] contrib_i = '0;
    logic       contrib_ready_o;
    logic [8:0] leak_i = '0;
    logic [8:0] threshold_i = '0;
    logic [8:0] reset_potential_i = '0;
    logic [0:0] reset_mode_i = '0;
    logic       spike_valid_o;
    logic       spike_ready_i = 1'b0;
    logic [8:0] potential_o;
    logic       busy_o;
    logic       done_o;
    logic       tick_overrun_o;

    int n_checks = 0;
    int n_fails  = 0;
    int pot_m    = 0;

    neuron_accumulator #(
        .NUM_AXONS(NA), .LEAK_WIDTH(9), .WEIGHT_WIDTH(9),
        .THRESHOLD_WIDTH(9), .POTENTIAL_WIDTH(P), .NUM_RESET_MODES(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(tick_i),
        .contrib_valid_i(contrib_valid_i), .contrib_i(contrib_i),
        .contrib_ready_o(contrib_ready_o), .leak_i(leak_i),
        .threshold_i(threshold_i), .reset_potential_i(reset_potential_i),
        .reset_mode_i(reset_mode_i), .spike_valid_o(spike_valid_o),
        .spike_ready_i(spike_ready_i), .potential_o(potential_o),
        .busy_o(busy_o), .done_o(done_o), .tick_overrun_o(tick_overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 255) return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    function automatic int pot_now();
        return int'($signed(potential_o));
    endfunction

    task automatic tick_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick_i = 1'b0;
        contrib_valid_i = 1'b0;
        spike_ready_i = 1'b0;
        tick_edge();
        check("rst_pot", pot_now(), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_spike", int'(spike_valid_o), 0);
        rst_ni = 1'b1;
        pot_m = 0;
    endtask

    // One full timestep: drive, model and check.
    task automatic run_ts(input int c[NA], input int leak, input int thr, input int mode,
                          input int rp, input bit gaps, input int rdelay,
                          input int ovr_at, input bit tick_fire);
        int  part, exp_pot, edges, gsum, g;
        bit  exp_spike;
        leak_i = 9'(leak);
        threshold_i = 9'(thr);
        reset_mode_i = 1'(mode);
        reset_potential_i = 9'(rp);
        spike_ready_i = 1'b0;
        part = pot_m;
        gsum = 0;

        tick_i = 1'b1;
        tick_edge();
        tick_i = 1'b0;
        edges = 1;
        check("busy_start", int'(busy_o), 1);
        check("ready_integ", int'(contrib_ready_o), 1);

        for (int i = 0; i < NA; i++) begin
            g = gaps ? int'($urandom_range(0, 3)) : 0;
            gsum += g;
            repeat (g) begin
                tick_edge();
                edges++;
            end
            contrib_valid_i = 1'b1;
            contrib_i = 9'(c[i]);
            if (i == ovr_at) tick_i = 1'b1;
            tick_edge();
            edges++;
            contrib_valid_i = 1'b0;
            part = sat(part + c[i]);
            check("acc", pot_now(), part);
            if (i == ovr_at) begin
                check("overrun_integ", int'(tick_overrun_o), 1);
                tick_i = 1'b0;
            end
        end

        tick_edge();
        edges++;
        part = sat(part + leak);
        check("leak", pot_now(), part);
        check("done_early", int'(done_o), 0);

        exp_spike = (part >= thr);
        if (exp_spike) exp_pot = (mode == 1) ? sat(part - thr) : rp;
        else exp_pot = part;

        if (tick_fire) tick_i = 1'b1;
        tick_edge();
        edges++;
        if (tick_fire) begin
            check("overrun_fire", int'(tick_overrun_o), 1);
            tick_i = 1'b0;
        end
        check("spike_valid", int'(spike_valid_o), int'(exp_spike));

        if (exp_spike) begin
            for (int k = 0; k < rdelay; k++) begin
                check("spike_hold", int'(spike_valid_o), 1);
                check("done_wait", int'(done_o), 0);
                tick_edge();
                edges++;
            end
            spike_ready_i = 1'b1;
            tick_edge();
            edges++;
            spike_ready_i = 1'b0;
            check("spike_drop", int'(spike_valid_o), 0);
        end

        check("done", int'(done_o), 1);
        check("final_pot", pot_now(), exp_pot);
        check("latency", edges, 7 + gsum + (exp_spike ? rdelay + 1 : 0));
        tick_edge();
        check("done_pulse", int'(done_o), 0);
        check("idle", int'(busy_o), 0);
        check("overrun_clear", int'(tick_overrun_o), 0);
        if (busy_o) begin
            spike_ready_i = 1'b1;
            tick_edge();
            spike_ready_i = 1'b0;
        end
        pot_m = exp_pot;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c[NA];
        int pot_a;

        do_reset();
        check("rst_ready", int'(contrib_ready_o), 0);
        check("rst_done", int'(done_o), 0);

        c = '{10, 20, -5, 3};
        run_ts(c, -1, 100, 0, 0, 1'b0, 0, -1, 1'b0);
        check("basic_27", pot_now(), 27);

        do_reset();
        c = '{10, 10, 10, 10};
        run_ts(c, 0, 20, 0, -3, 1'b0, 0, -1, 1'b0);
        check("abs_reset", pot_now(), -3);

        do_reset();
        run_ts(c, 0, 20, 1, 0, 1'b0, 5, -1, 1'b0);
        check("lin_reset", pot_now(), 20);

        do_reset();
        c = '{255, 255, 255, 255};
        run_ts(c, 10, 255, 0, 255, 1'b0, 0, -1, 1'b0);
        check("sat_hi", pot_now(), 255);
        c = '{-255, -255, -255, -255};
        run_ts(c, -10, 100, 0, 0, 1'b0, 0, -1, 1'b0);
        check("sat_lo", pot_now(), -256);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NA; i++) c[i] = int'($urandom_range(0, 511)) - 256;
            do_reset();
            run_ts(c, -3, 50, 1, 0, 1'b0, 0, -1, 1'b0);
            pot_a = pot_now();
            do_reset();
            run_ts(c, -3, 50, 1, 0, 1'b1, 0, -1, 1'b0);
            check("gap_equiv", pot_now(), pot_a);
        end

        c = '{5, 6, 7, 8};
        run_ts(c, 0, 200, 0, 0, 1'b0, 0, 1, 1'b0);
        c = '{1, 1, 1, 1};
        run_ts(c, 0, 255, 0, 0, 1'b0, 0, -1, 1'b1);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < NA; i++) c[i] = int'($urandom_range(0, 511)) - 256;
            run_ts(c, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 511)) - 256,
                   1'b1, int'($urandom_range(0, 3)), -1, 1'b0);
        end

        do_reset();
        tick_i = 1'b1;
        tick_edge();
        tick_i = 1'b0;
        contrib_valid_i = 1'b1;
        contrib_i = 9'(40);
        tick_edge();
        tick_edge();
        contrib_valid_i = 1'b0;
        check("pre_async", pot_now(), 80);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_pot", pot_now(), 0);
        check("async_busy", int'(busy_o), 0);
        check("async_ready", int'(contrib_ready_o), 0);
        check("async_spike", int'(spike_valid_o), 0);
        check("async_done", int'(done_o), 0);
        check("async_ovr", int'(tick_overrun_o), 0);
        tick_edge();
        rst_ni = 1'b1;
        pot_m = 0;
        c = '{3, 4, 5, 6};
        run_ts(c, 0, 100, 0, 0, 1'b0, 0, -1, 1'b0);
        check("post_async", pot_now(), 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
